// File: rtl/iter_alu_if.sv
// Request/response bundle for the iterative ALU: request handshake with operands,
// result handshake with result words and status flags.
interface iter_alu_if #(
   parameter int NUMBITS = 16
);
   logic               in_valid;
   logic               in_ready;
   logic [NUMBITS-1:0] A;
   logic [NUMBITS-1:0] B;
   logic [3:0]         opcode;
   logic               out_valid;
   logic               out_ready;
   logic [NUMBITS-1:0] result;
   logic [NUMBITS-1:0] result_hi;
   logic               carryout;
   logic               overflow;
   logic               zero;
   logic               err;

   modport master (
      output in_valid, A, B, opcode, out_ready,
      input  in_ready, out_valid, result, result_hi, carryout, overflow, zero, err
   );

   modport slave (
      input  in_valid, A, B, opcode, out_ready,
      output in_ready, out_valid, result, result_hi, carryout, overflow, zero, err
   );
endinterface

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle add/sub/logic/shift, NUMBITS-cycle shift-add multiply
// and restoring divide, results held until the consumer takes them.
//
// state | meaning
// IDLE  | ready for a request (in_ready=1)
// BUSY  | one multiply/divide step per cycle, NUMBITS cycles
// DONE  | result valid and held until out_ready
module iter_alu #(
   parameter int NUMBITS = 16
) (
   input logic        clk,
   input logic        reset,
   iter_alu_if.slave  bus
);
   localparam int CW = (NUMBITS > 2) ? $clog2(NUMBITS) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt;
   logic               is_mul;
   logic [NUMBITS-1:0] opnd_q, hi_q, lo_q;
   logic [NUMBITS-1:0] res_q, res_hi_q;
   logic               carry_q, ovf_q, zero_q, err_q;

   logic               accept, multi;
   logic [NUMBITS:0]   sum;
   logic [NUMBITS-1:0] diff;
   logic [NUMBITS-1:0] sc_r, sc_rh;
   logic               sc_c, sc_ov, sc_err, sc_zero;
   logic [NUMBITS:0]   mul_sum, div_sh;
   logic [NUMBITS-1:0] div_diff, step_hi, step_lo;
   logic               div_ge;

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.result    = res_q;
   assign bus.result_hi = res_hi_q;
   assign bus.carryout  = carry_q;
   assign bus.overflow  = ovf_q;
   assign bus.zero      = zero_q;
   assign bus.err       = err_q;

   assign accept = bus.in_valid && (state == IDLE);
   assign multi  = (bus.opcode == 4'd9) || ((bus.opcode == 4'd10) && (bus.B != '0));

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = multi ? BUSY : DONE;
         BUSY:    if (cnt == '0) state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sum     = {1'b0, bus.A} + {1'b0, bus.B};
      diff    = bus.A - bus.B;
      sc_r    = '0;
      sc_rh   = '0;
      sc_c    = 1'b0;
      sc_ov   = 1'b0;
      sc_err  = 1'b0;
      unique case (bus.opcode)
         4'd0: begin sc_r = sum[NUMBITS-1:0]; sc_c = sum[NUMBITS]; end
         4'd1: begin
            sc_r  = sum[NUMBITS-1:0];
            sc_ov = (bus.A[NUMBITS-1] == bus.B[NUMBITS-1]) && (sc_r[NUMBITS-1] != bus.A[NUMBITS-1]);
         end
         4'd2: begin sc_r = diff; sc_c = (bus.A < bus.B); end
         4'd3: begin
            sc_r  = diff;
            sc_ov = (bus.A[NUMBITS-1] != bus.B[NUMBITS-1]) && (sc_r[NUMBITS-1] != bus.A[NUMBITS-1]);
         end
         4'd4: sc_r = bus.A & bus.B;
         4'd5: sc_r = bus.A | bus.B;
         4'd6: sc_r = bus.A ^ bus.B;
         4'd7: sc_r = {1'b0, bus.A[NUMBITS-1:1]};
         4'd8: sc_r = {bus.A[NUMBITS-1], bus.A[NUMBITS-1:1]};
         4'd10: begin sc_r = '1; sc_rh = bus.A; sc_err = 1'b1; end  // only reached with B==0
         default: sc_err = 1'b1;
      endcase
      // illegal opcodes report zero=0 even though result is 0
      sc_zero = (sc_r == '0) && !(sc_err && bus.opcode != 4'd10);
   end

   // multiply: {hi,lo} shifts right, lo starts as B; divide: {rem=hi, quo=lo} shifts left
   always_comb begin
      mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      div_sh   = {hi_q, lo_q[NUMBITS-1]};
      div_ge   = (div_sh >= {1'b0, opnd_q});
      div_diff = div_sh[NUMBITS-1:0] - opnd_q;
      if (is_mul) begin
         step_hi = mul_sum[NUMBITS:1];
         step_lo = {mul_sum[0], lo_q[NUMBITS-1:1]};
      end else begin
         step_hi = div_ge ? div_diff : div_sh[NUMBITS-1:0];
         step_lo = {lo_q[NUMBITS-2:0], div_ge};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         is_mul   <= 1'b0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         res_q    <= '0;
         res_hi_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && accept) begin
            if (multi) begin
               cnt    <= CW'(NUMBITS-1);
               is_mul <= (bus.opcode == 4'd9);
               opnd_q <= (bus.opcode == 4'd9) ? bus.A : bus.B;
               lo_q   <= (bus.opcode == 4'd9) ? bus.B : bus.A;
               hi_q   <= '0;
            end else begin
               res_q    <= sc_r;
               res_hi_q <= sc_rh;
               carry_q  <= sc_c;
               ovf_q    <= sc_ov;
               zero_q   <= sc_zero;
               err_q    <= sc_err;
            end
         end else if (state == BUSY) begin
            hi_q <= step_hi;
            lo_q <= step_lo;
            if (cnt != '0) begin
               cnt <= cnt - CW'(1);
            end else begin
               res_q    <= step_lo;
               res_hi_q <= step_hi;
               carry_q  <= 1'b0;
               ovf_q    <= is_mul && (step_hi != '0);
               zero_q   <= (step_lo == '0) && (!is_mul || step_hi == '0);
               err_q    <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_iter_alu.sv
// Randomized and directed bench for iter_alu (NUMBITS=16) against an arithmetic model.
module tb_iter_alu;
   typedef struct packed {
      logic [15:0] r;
      logic [15:0] rh;
      logic        c;
      logic        ov;
      logic        z;
      logic        e;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad = 0;
   exp_t exp_q;
   logic exp_pending = 1'b0;
   exp_t g, m;

   iter_alu_if #(.NUMBITS(16)) bus();

   iter_alu #(.NUMBITS(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
      exp_t e;
      int sa, sb, si;
      int unsigned ua, ub, u;
      e  = '0;
      ua = a;
      ub = b;
      sa = $signed(a);
      sb = $signed(b);
      u  = 0;
      case (op)
         4'd0: begin u = ua + ub; e.r = u[15:0]; e.c = (u > 32'd65535); end
         4'd1: begin si = sa + sb; e.r = si[15:0]; e.ov = (si > 32767) || (si < -32768); end
         4'd2: begin u = ua - ub; e.r = u[15:0]; e.c = (ua < ub); end
         4'd3: begin si = sa - sb; e.r = si[15:0]; e.ov = (si > 32767) || (si < -32768); end
         4'd4: e.r = a & b;
         4'd5: e.r = a | b;
         4'd6: e.r = a ^ b;
         4'd7: e.r = a >> 1;
         4'd8: begin si = sa >>> 1; e.r = si[15:0]; end
         4'd9: begin u = ua * ub; e.r = u[15:0]; e.rh = u[31:16]; e.ov = (u > 32'd65535); end
         4'd10: begin
            if (b == 0) begin e.r = 16'hFFFF; e.rh = a; e.e = 1'b1; end
            else begin u = ua / ub; e.r = u[15:0]; u = ua % ub; e.rh = u[15:0]; end
         end
         default: e.e = 1'b1;
      endcase
      if (op == 4'd9) e.z = (e.r == 0) && (e.rh == 0);
      else if (op <= 4'd10) e.z = (e.r == 0);
      return e;
   endfunction

   function automatic int exp_lat(input logic [3:0] op, input logic [15:0] b);
      return (op == 4'd9 || (op == 4'd10 && b != 0)) ? 17 : 1;
   endfunction

   // every cycle a result is presented it must match the model and stay put
   always @(negedge clk) begin
      if (reset && bus.out_valid) begin
         chk("spurious_out_valid", {31'd0, bus.out_valid}, {31'd0, exp_pending});
         if (exp_pending) begin
            chk("mon_result", bus.result, exp_q.r);
            chk("mon_result_hi", bus.result_hi, exp_q.rh);
            chk("mon_carryout", bus.carryout, exp_q.c);
            chk("mon_overflow", bus.overflow, exp_q.ov);
            chk("mon_zero", bus.zero, exp_q.z);
            chk("mon_err", bus.err, exp_q.e);
         end
      end
   end

   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                        input int hold, output exp_t got);
      int n;
      chk("pre_in_ready", bus.in_ready, 1);
      bus.A = a; bus.B = b; bus.opcode = op; bus.in_valid = 1'b1;
      @(posedge clk);
      exp_q = model(a, b, op);
      exp_pending = 1'b1;
      #1;
      bus.in_valid = 1'b0;
      bus.A = 16'($urandom); bus.B = 16'($urandom); bus.opcode = 4'($urandom);
      n = 1;
      while (!bus.out_valid && n < 40) begin
         chk("busy_in_ready", bus.in_ready, 0);
         bus.in_valid = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency", n, exp_lat(op, b));
      got.r = bus.result; got.rh = bus.result_hi; got.c = bus.carryout;
      got.ov = bus.overflow; got.z = bus.zero; got.e = bus.err;
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = ~bus.in_valid;
         bus.A = 16'($urandom);
         @(posedge clk);
         #1;
         chk("done_in_ready", bus.in_ready, 0);
         chk("done_out_valid", bus.out_valid, 1);
      end
      bus.out_ready = 1'b1;
      bus.in_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      exp_pending = 1'b0;
      chk("handoff_out_valid", bus.out_valid, 0);
      chk("handoff_in_ready", bus.in_ready, 1);
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b0;
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic [3:0]  rop;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.A = '0; bus.B = '0; bus.opcode = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_result", {bus.result, bus.result_hi}, 0);
      chk("rst_flags", {bus.carryout, bus.overflow, bus.zero, bus.err}, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      m = model(16'h1234, 16'h0100, 4'd9);
      chk("model_mul", {m.rh, m.r}, 32'h0012_3400);
      m = model(16'h8000, 16'h0001, 4'd3);
      chk("model_ssub", {m.r, 12'd0, m.c, m.ov, m.z, m.e}, {16'h7FFF, 16'h0004});

      do_op(16'hFFFF, 16'h0001, 4'd0, 0, g);
      chk("uadd_r", g.r, 16'h0000);
      chk("uadd_flags", {g.c, g.ov, g.z, g.e}, 4'b1010);
      do_op(16'h7FFF, 16'h0001, 4'd1, 1, g);
      chk("sadd_r", g.r, 16'h8000);
      chk("sadd_flags", {g.c, g.ov, g.z, g.e}, 4'b0100);
      do_op(16'h8000, 16'h0001, 4'd3, 0, g);
      chk("ssub_r", g.r, 16'h7FFF);
      chk("ssub_ov", g.ov, 1);
      do_op(16'h1234, 16'h0100, 4'd9, 0, g);
      chk("mul_r", {g.rh, g.r}, 32'h0012_3400);
      chk("mul_ov", g.ov, 1);
      do_op(16'd100, 16'd7, 4'd10, 0, g);
      chk("div_r", {g.rh, g.r}, {16'd2, 16'd14});
      do_op(16'd100, 16'd0, 4'd10, 0, g);
      chk("div0_r", {g.rh, g.r}, {16'h0064, 16'hFFFF});
      chk("div0_err", g.e, 1);
      do_op(16'h5A5A, 16'h0F0F, 4'd6, 5, g);
      chk("hold_xor", g.r, 16'h5555);
      do_op(16'h1234, 16'h0000, 4'd12, 0, g);
      chk("illegal_flags", {g.r, g.c, g.ov, g.z, g.e}, {16'h0, 4'b0001});

      // reset in the fifth BUSY cycle of a multiply
      bus.A = 16'h1234; bus.B = 16'h0100; bus.opcode = 4'd9; bus.in_valid = 1'b1;
      @(posedge clk);
      exp_q = model(16'h1234, 16'h0100, 4'd9);
      exp_pending = 1'b1;
      #1;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b0;
      exp_pending = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_out_valid", bus.out_valid, 0);
      chk("abort_in_ready", bus.in_ready, 1);
      chk("abort_result", {bus.result, bus.result_hi}, 0);
      chk("abort_flags", {bus.carryout, bus.overflow, bus.zero, bus.err}, 0);
      reset = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      do_op(16'hF0F0, 16'h0FF0, 4'd4, 0, g);
      chk("and_r", g.r, 16'h00F0);

      for (int k = 0; k < 150; k++) begin
         rop = 4'($urandom_range(0, 15));
         if (k % 3 == 0) rop = 4'($urandom_range(9, 10));
         ra  = 16'($urandom);
         rb  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
         if (k % 5 == 0) rb = 16'($urandom_range(0, 3));
         do_op(ra, rb, rop, $urandom_range(0, 3), g);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter: NUMBITS, 16, operand/result width in bits; SHALL be >= 2.
REQ-002 Clocking: the block SHALL use one clock; reset is synchronous and active-low.
REQ-003 Ports, clock and reset first:
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request.
- A  in  NUMBITS  operand A.
- B  in  NUMBITS  operand B.
- opcode  in  4  operation select.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- result  out  NUMBITS  primary result (sum, logic result, product low half, quotient).
- result_hi  out  NUMBITS  product high half or remainder; 0 for other ops.
- carryout  out  1  unsigned carry/borrow.
- overflow  out  1  signed overflow, or product exceeds NUMBITS.
- zero  out  1  result (and result_hi for MUL) all zero.
- err  out  1  illegal opcode or divide by zero.

Function
REQ-004 Opcodes: 0000 unsigned add; 0001 signed add; 0010 unsigned sub; 0011 signed sub; 0100 AND; 0101 OR; 0110 XOR; 0111 A>>1 logical; 1000 A>>>1 arithmetic; 1001 unsigned MUL; 1010 unsigned DIV; 1011-1111 illegal.
REQ-005 FSM states IDLE, BUSY, DONE; in_ready SHALL be 1 exactly when state is IDLE.
REQ-006 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; A, B, opcode SHALL be captured then, later input changes ignored.
REQ-007 Single-cycle ops, illegal opcodes and DIV by zero: IDLE->DONE on accept; out_valid=1 in the cycle after accept.
REQ-008 MUL and DIV (B!=0): IDLE->BUSY on accept; BUSY SHALL last exactly NUMBITS cycles (shift-add multiply, restoring divide); then DONE; out_valid=1 NUMBITS+1 cycles after accept.
REQ-009 DONE: result, result_hi, flags SHALL be held stable while out_valid=1; on out_valid=1 and out_ready=1 go IDLE, out_valid=0 next cycle.
REQ-010 in_valid SHALL be ignored in BUSY and DONE; no request accepted in the handoff cycle.
REQ-011 Add/sub SHALL compute modulo 2^NUMBITS.
REQ-012 Unsigned add: carryout=carry out of MSB. Unsigned sub: carryout=1 iff A<B (borrow); overflow=0.
REQ-013 Signed add: overflow=1 iff A,B same sign and result sign differs. Signed sub: overflow=1 iff A,B signs differ and result sign differs from A; carryout=0.
REQ-014 MUL: {result_hi,result}=A*B (2*NUMBITS bits); overflow=1 iff result_hi!=0; carryout=0.
REQ-015 DIV: result=quotient, result_hi=remainder; B=0 SHALL give result all ones, result_hi=A, err=1.
REQ-016 Logic and shift ops: carryout=0, overflow=0, result_hi=0.
REQ-017 Illegal opcode: result=0, result_hi=0, carryout=0, overflow=0, zero=0, err=1.
REQ-018 zero=1 iff result==0 (MUL: result and result_hi both 0), except illegal opcode; err=0 for all legal non-faulting ops.

Reset
REQ-019 reset=0 at a rising edge SHALL force state IDLE and clear out_valid, result, result_hi, carryout, overflow, zero, err, internal counter; in_ready=1 from the next cycle.
REQ-020 Reset in BUSY or DONE SHALL abort the operation; no out_valid for it afterwards.
REQ-021 Reset SHALL take priority over accept and handoff in the same cycle.

Verification (NUMBITS=16)
REQ-022 Uadd 0xFFFF+0x0001 -> result 0x0000, carryout 1, zero 1, overflow 0, out_valid 1 cycle after accept.
REQ-023 Sadd 0x7FFF+0x0001 -> 0x8000, overflow 1, carryout 0; ssub 0x8000-0x0001 -> 0x7FFF, overflow 1.
REQ-024 MUL 0x1234*0x0100 -> result 0x3400, result_hi 0x0012, overflow 1; out_valid 17 cycles after accept; in_ready 0 throughout.
REQ-025 DIV 100/7 -> result 14, result_hi 2, latency 17; DIV 100/0 -> result 0xFFFF, result_hi 0x0064, err 1, latency 1.
REQ-026 out_ready held 0 for 5 cycles in DONE with in_valid toggling -> outputs stable, no accept; handoff on out_ready=1, in_ready=1 next cycle.
REQ-027 reset=0 in 5th BUSY cycle of MUL -> next cycle out_valid 0, all outputs 0, in_ready 1; following AND 0xF0F0&0x0FF0 -> 0x00F0.
